decode_stage: RTL and testbench
===============================

# decode_stage

Decode stage of the Y86-64 pipeline, with its two bracketing pipeline registers. It latches fetch outputs into the D register, derives source and destination register IDs, and reads the 15-entry register file. It resolves data hazards by forwarding from execute, memory and write-back, and latches the result into the E register consumed by `execute`. The register file lives here and is written from the W-stage inputs.

## Interface
Parameters:
- `RNONE`, 4'hF, "no register" ID
- `RSP`, 4'h4, stack pointer ID
- `S_AOK`, 3'b001, status AOK (bit0); INS = 3'b010, HLT = 3'b100

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `D_stall`, `D_bubble`, `E_bubble`  in  1 each  pipeline control from hazard logic
- `f_stat` in 3, `f_icode` in 4, `f_ifun` in 4, `f_rA` in 4, `f_rB` in 4, `f_valC` in 64, `f_valP` in 64  fetch outputs
- `e_dstE` in 4, `e_valE` in 64  execute-stage result (combinational; already RNONE if cmov not taken)
- `M_dstE` in 4, `M_valE` in 64, `M_dstM` in 4, `m_valM` in 64  memory stage
- `W_dstE` in 4, `W_valE` in 64, `W_dstM` in 4, `W_valM` in 64  write-back; also register-file write ports
- `d_srcA`, `d_srcB`  out  4  combinational source IDs, for load-use detection
- `E_stat` out 3, `E_icode` out 4, `E_ifun` out 4, `E_valC` out 64, `E_valA` out 64, `E_valB` out 64, `E_dstE` out 4, `E_dstM` out 4, `E_srcA` out 4, `E_srcB` out 4  E register
- `dbg_sel`  in  4  register to observe
- `dbg_val`  out  64  `rf[dbg_sel]`; 0 when `dbg_sel` is F

## Operation
D register (D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP):
- `D_stall`: hold.
- `D_bubble`: load the bubble value: stat = AOK, icode = 1 (nop), ifun = 0, rA = rB = F, valC = valP = 0.
- Both asserted: stall wins.
- Neither asserted: load the `f_*` inputs.

Source and destination selection, from D_icode:
- srcA = rA for {2, 4, 6, A}; RSP for {9, B}; else F.
- srcB = rB for {4, 5, 6}; RSP for {8, 9, A, B}; else F.
- dstE = rB for {2, 3, 6}; RSP for {8, 9, A, B}; else F.
- dstM = rA for {5, B}; else F.

valA priority, first match wins:
1. icode in {7, 8}: D_valP.
2. srcA == F: 0.
3. srcA == e_dstE: e_valE.
4. srcA == M_dstM: m_valM.
5. srcA == M_dstE: M_valE.
6. srcA == W_dstM: W_valM.
7. srcA == W_dstE: W_valE.
8. Otherwise rf[srcA].

valB: same chain using srcB, without step 1.

Register file:
- 15 × 64 bits, asynchronous read.
- At the rising edge, writes `W_valE` to `W_dstE` and `W_valM` to `W_dstM`; a port whose ID is F does not write.
- When both ports target the same register, the M port wins.
- A same-cycle read of a register being written returns the new value, via forwarding rules 6–7.

E register:
- `E_bubble`: load the bubble value: stat = AOK, icode = 1, ifun = 0, all IDs = F, all values = 0.
- Otherwise: load the decode results.
- The E register is never stalled.

Reset (`rst_n` low):
- D and E registers take their bubble values.
- All rf entries clear to 0.
- `dbg_val` reflects the cleared file.
- Deassertion is synchronized externally.

## Timing
- An instruction on `f_*` before edge n is in D after n, and appears on the E outputs after edge n+1.
- `d_srcA`/`d_srcB` are valid combinationally in the cycle after edge n.
- A register-file write committed at edge k is visible through `dbg_val` after k.
- Forwarding paths are combinational within the cycle; there are no internal bubbles.
- Reset mid-operation: all in-flight D and E contents are discarded immediately (asynchronous).

## Test plan
- **Reset:** `rst_n` = 0 mid-run → E_icode = 1, E_stat = 001, E_dstE = F, dbg_val(rf[3]) = 0 without waiting for a clock edge.
- **Plain decode:** W writes rf[2] = 7 and rf[3] = 9; then issue `6 0 2 3` (addq %rdx,%rbx) with no forwarding hits → E_valA = 7, E_valB = 9, E_dstE = 3, E_dstM = F after 2 edges.
- **Forward priority:** srcA = 2 with e_dstE = 2 / e_valE = 11, M_dstE = 2 / M_valE = 22 and W_dstE = 2 → E_valA = 11. Drop the e match → 22.
- **Stack ops:** with rf[4] = 0x100, issue `call` (icode 8, valP = 0x2A) → E_valA = 0x2A, E_valB = 0x100, E_dstE = 4. Issue `popq` rA = 5 → E_srcA = E_srcB = 4, E_dstM = 5.
- **Stall/bubble:** `D_stall` held 2 cycles → the E outputs repeat the same decoded instruction, and f changes are ignored. `E_bubble` with `D_stall` → E = nop bubble, D retained. `D_stall` + `D_bubble` → D holds.
- **Dual write:** W_dstE = W_dstM = 6, W_valE = 1, W_valM = 2 → rf[6] = 2. W_dstE = F → no write occurs.

Source files
------------

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, register file with operand forwarding,
// and the E pipeline register that feeds execute.
module decode_stage #(
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [3:0] RSP   = 4'h4,
    parameter logic [2:0] S_AOK = 3'b001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic        E_bubble,
    input  logic [2:0]  f_stat,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_valE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [2:0]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_val
);

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dreg_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
    } ereg_t;

    localparam dreg_t DBubble = '{stat: S_AOK, icode: 4'h1, ifun: 4'h0, ra: RNONE, rb: RNONE,
                                  valc: 64'h0, valp: 64'h0};
    localparam ereg_t EBubble = '{stat: S_AOK, icode: 4'h1, ifun: 4'h0, valc: 64'h0,
                                  vala: 64'h0, valb: 64'h0, dste: RNONE, dstm: RNONE,
                                  srca: RNONE, srcb: RNONE};

    dreg_t       dreg_d, dreg_q;
    ereg_t       ereg_d, ereg_q;
    logic [63:0] rf_q [15];
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] val_a, val_b;

    // D register: stall takes precedence over bubble.
    always_comb begin
        dreg_d = dreg_q;
        if (!D_stall) begin
            if (D_bubble) begin
                dreg_d = DBubble;
            end else begin
                dreg_d = '{stat: f_stat, icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB,
                           valc: f_valC, valp: f_valP};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dreg_q <= DBubble;
        end else begin
            dreg_q <= dreg_d;
        end
    end

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (dreg_q.icode)
            4'h2, 4'h4, 4'h6, 4'hA: src_a = dreg_q.ra;
            4'h9, 4'hB:             src_a = RSP;
            default:                src_a = RNONE;
        endcase
        case (dreg_q.icode)
            4'h4, 4'h5, 4'h6:       src_b = dreg_q.rb;
            4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
            default:                src_b = RNONE;
        endcase
        case (dreg_q.icode)
            4'h2, 4'h3, 4'h6:       dst_e = dreg_q.rb;
            4'h8, 4'h9, 4'hA, 4'hB: dst_e = RSP;
            default:                dst_e = RNONE;
        endcase
        case (dreg_q.icode)
            4'h5, 4'hB: dst_m = dreg_q.ra;
            default:    dst_m = RNONE;
        endcase
    end

    // Forwarding: youngest producer wins; W-stage matches cover same-cycle RF writes.
    always_comb begin
        val_a = 64'h0;
        if (dreg_q.icode == 4'h7 || dreg_q.icode == 4'h8) val_a = dreg_q.valp;
        else if (src_a == RNONE)  val_a = 64'h0;
        else if (src_a == e_dstE) val_a = e_valE;
        else if (src_a == M_dstM) val_a = m_valM;
        else if (src_a == M_dstE) val_a = M_valE;
        else if (src_a == W_dstM) val_a = W_valM;
        else if (src_a == W_dstE) val_a = W_valE;
        else                      val_a = rf_q[src_a];

        val_b = 64'h0;
        if (src_b == RNONE)       val_b = 64'h0;
        else if (src_b == e_dstE) val_b = e_valE;
        else if (src_b == M_dstM) val_b = m_valM;
        else if (src_b == M_dstE) val_b = M_valE;
        else if (src_b == W_dstM) val_b = W_valM;
        else if (src_b == W_dstE) val_b = W_valE;
        else                      val_b = rf_q[src_b];
    end

    // Register file; the M port overrides the E port on a shared destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) rf_q[i] <= 64'h0;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (W_dstM == 4'(i))      rf_q[i] <= W_valM;
                else if (W_dstE == 4'(i)) rf_q[i] <= W_valE;
            end
        end
    end

    always_comb begin
        ereg_d = EBubble;
        if (!E_bubble) begin
            ereg_d = '{stat: dreg_q.stat, icode: dreg_q.icode, ifun: dreg_q.ifun,
                       valc: dreg_q.valc, vala: val_a, valb: val_b, dste: dst_e,
                       dstm: dst_m, srca: src_a, srcb: src_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ereg_q <= EBubble;
        end else begin
            ereg_q <= ereg_d;
        end
    end

    assign d_srcA  = src_a;
    assign d_srcB  = src_b;
    assign E_stat  = ereg_q.stat;
    assign E_icode = ereg_q.icode;
    assign E_ifun  = ereg_q.ifun;
    assign E_valC  = ereg_q.valc;
    assign E_valA  = ereg_q.vala;
    assign E_valB  = ereg_q.valb;
    assign E_dstE  = ereg_q.dste;
    assign E_dstM  = ereg_q.dstm;
    assign E_srcA  = ereg_q.srca;
    assign E_srcB  = ereg_q.srcb;
    assign dbg_val = (dbg_sel == RNONE) ? 64'h0 : rf_q[dbg_sel];

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vector table, corner-case sequences and
// randomized traffic checked against a behavioural pipeline model.
module tb_decode_stage;

    localparam logic [3:0] F = 4'hF;
    localparam logic [3:0] SP = 4'h4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        D_stall, D_bubble, E_bubble;
    logic [2:0]  f_stat;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  dbg_sel;
    logic [63:0] dbg_val;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_stat(E_stat), .E_icode(E_icode),
        .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .dbg_sel(dbg_sel), .dbg_val(dbg_val)
    );

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
    } dreg_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun;
        logic [63:0] valc, vala, valb;
        logic [3:0]  dste, dstm, srca, srcb;
    } ereg_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [63:0] xa, xb;
        logic [3:0]  xdste, xdstm, xsrca, xsrcb;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    dreg_t       md;
    ereg_t       me;
    logic [63:0] mrf [15];
    vec_t        vecs [11];
    ereg_t       dut_e;

    assign dut_e = '{stat: E_stat, icode: E_icode, ifun: E_ifun, valc: E_valC, vala: E_valA,
                     valb: E_valB, dste: E_dstE, dstm: E_dstM, srca: E_srcA, srcb: E_srcB};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic dreg_t d_bub();
        return '{stat: 3'b001, icode: 4'h1, ifun: 4'h0, ra: F, rb: F, valc: 0, valp: 0};
    endfunction

    function automatic ereg_t e_bub();
        return '{stat: 3'b001, icode: 4'h1, ifun: 4'h0, valc: 0, vala: 0, valb: 0,
                 dste: F, dstm: F, srca: F, srcb: F};
    endfunction

    function automatic logic [3:0] m_srca(dreg_t d);
        if (d.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return d.ra;
        if (d.icode inside {4'h9, 4'hB}) return SP;
        return F;
    endfunction

    function automatic logic [3:0] m_srcb(dreg_t d);
        if (d.icode inside {4'h4, 4'h5, 4'h6}) return d.rb;
        if (d.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return SP;
        return F;
    endfunction

    // Operand value seen by decode: newest in-flight producer, else the file.
    function automatic logic [63:0] m_operand(logic [3:0] s);
        if (s == F) return 0;
        if (s == e_dstE) return e_valE;
        if (s == M_dstM) return m_valM;
        if (s == M_dstE) return M_valE;
        if (s == W_dstM) return W_valM;
        if (s == W_dstE) return W_valE;
        return mrf[s];
    endfunction

    function automatic ereg_t m_decode(dreg_t d);
        ereg_t r;
        r.stat = d.stat;
        r.icode = d.icode;
        r.ifun = d.ifun;
        r.valc = d.valc;
        r.srca = m_srca(d);
        r.srcb = m_srcb(d);
        r.dste = (d.icode inside {4'h2, 4'h3, 4'h6}) ? d.rb :
                 (d.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? SP : F;
        r.dstm = (d.icode inside {4'h5, 4'hB}) ? d.ra : F;
        r.vala = (d.icode inside {4'h7, 4'h8}) ? d.valp : m_operand(r.srca);
        r.valb = m_operand(r.srcb);
        return r;
    endfunction

    task automatic tick();
        ereg_t nxt_e;
        dreg_t nxt_d;
        nxt_e = E_bubble ? e_bub() : m_decode(md);
        nxt_d = D_stall ? md : D_bubble ? d_bub() :
                '{stat: f_stat, icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB,
                  valc: f_valC, valp: f_valP};
        @(posedge clk);
        #1;
        if (W_dstE != F) mrf[W_dstE] = W_valE;
        if (W_dstM != F) mrf[W_dstM] = W_valM;
        md = nxt_d;
        me = nxt_e;
        check("ereg", dut_e, me);
        check("d_srcA", d_srcA, m_srca(md));
        check("d_srcB", d_srcB, m_srcb(md));
        check("dbg_val", dbg_val, (dbg_sel == F) ? 64'h0 : mrf[dbg_sel]);
    endtask

    task automatic set_idle();
        D_stall = 0; D_bubble = 0; E_bubble = 0;
        f_stat = 3'b001; f_icode = 4'h1; f_ifun = 0; f_rA = F; f_rB = F;
        f_valC = 0; f_valP = 0;
        e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F;
        e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    endtask

    task automatic set_f(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp);
        f_stat = st; f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
    endtask

    task automatic wr(input logic [3:0] id, input logic [63:0] v);
        W_dstE = id; W_valE = v;
        tick();
        W_dstE = F;
    endtask

    // Asserted away from any clock edge; outputs must clear before the next edge.
    task automatic do_reset();
        dbg_sel = 4'h3;
        rst_n = 0;
        #1;
        check("rst_E_icode", E_icode, 4'h1);
        check("rst_E_stat", E_stat, 3'b001);
        check("rst_E_dstE", E_dstE, F);
        check("rst_dbg_rf3", dbg_val, 64'h0);
        md = d_bub();
        me = e_bub();
        for (int i = 0; i < 15; i++) mrf[i] = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        check("rst_ereg", dut_e, me);
    endtask

    initial begin
        vecs[0]  = '{3'b001, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0,  64'h2,  64'h7,   64'h9,   4'h3, F,    4'h2, 4'h3};
        vecs[1]  = '{3'b001, 4'h8, 4'h0, F,    F,    64'h40, 64'h2A, 64'h2A,  64'h100, 4'h4, F,    F,    4'h4};
        vecs[2]  = '{3'b001, 4'hB, 4'h0, 4'h5, F,    64'h0,  64'h2,  64'h100, 64'h100, 4'h4, 4'h5, 4'h4, 4'h4};
        vecs[3]  = '{3'b001, 4'hA, 4'h0, 4'h6, F,    64'h0,  64'h2,  64'h16,  64'h100, 4'h4, F,    4'h6, 4'h4};
        vecs[4]  = '{3'b001, 4'h3, 4'h0, F,    4'h7, 64'h55, 64'hA,  64'h0,   64'h0,   4'h7, F,    F,    F};
        vecs[5]  = '{3'b001, 4'h2, 4'h3, 4'h1, 4'h0, 64'h0,  64'h2,  64'h11,  64'h0,   4'h0, F,    4'h1, F};
        vecs[6]  = '{3'b001, 4'h5, 4'h0, 4'h0, 4'h6, 64'h8,  64'hA,  64'h0,   64'h16,  F,    4'h0, F,    4'h6};
        vecs[7]  = '{3'b001, 4'h4, 4'h0, 4'h3, 4'h1, 64'h8,  64'hA,  64'h9,   64'h11,  F,    F,    4'h3, 4'h1};
        vecs[8]  = '{3'b001, 4'h7, 4'h1, F,    F,    64'h80, 64'h99, 64'h99,  64'h0,   F,    F,    F,    F};
        vecs[9]  = '{3'b001, 4'h9, 4'h0, F,    F,    64'h0,  64'h1,  64'h100, 64'h100, 4'h4, F,    4'h4, 4'h4};
        vecs[10] = '{3'b100, 4'h0, 4'h0, F,    F,    64'h0,  64'h1,  64'h0,   64'h0,   F,    F,    F,    F};

        set_idle();
        dbg_sel = 4'h3;
        #2;
        do_reset();

        // Register file preload: rf[i] = 0x10+i, then rf[2]=7, rf[3]=9, rf[4]=0x100.
        for (int i = 0; i < 15; i++) wr(4'(i), 64'h10 + 64'(i));
        wr(4'h2, 64'h7);
        wr(4'h3, 64'h9);
        wr(4'h4, 64'h100);

        for (int v = 0; v < 11; v++) begin
            set_f(vecs[v].stat, vecs[v].icode, vecs[v].ifun, vecs[v].ra, vecs[v].rb,
                  vecs[v].valc, vecs[v].valp);
            tick();
            set_f(3'b001, 4'h1, 4'h0, F, F, 0, 0);
            tick();
            check($sformatf("vec%0d", v),
                  {E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB},
                  {vecs[v].stat, vecs[v].icode, vecs[v].ifun, vecs[v].valc, vecs[v].xa, vecs[v].xb,
                   vecs[v].xdste, vecs[v].xdstm, vecs[v].xsrca, vecs[v].xsrcb});
        end

        // Forwarding priority on srcA = 2.
        set_f(3'b001, 4'h6, 4'h0, 4'h2, 4'h3, 0, 2);
        tick();
        e_dstE = 4'h2; e_valE = 64'd11;
        M_dstE = 4'h2; M_valE = 64'd22;
        W_dstE = 4'h2; W_valE = 64'd33;
        tick();
        check("fwd_e", E_valA, 64'd11);
        e_dstE = F;
        tick();
        check("fwd_m", E_valA, 64'd22);
        set_idle();

        // D stall: E repeats the held instruction and f changes are ignored.
        set_f(3'b001, 4'h6, 4'h0, 4'h2, 4'h3, 0, 2);
        tick();
        D_stall = 1;
        set_f(3'b001, 4'h3, 4'h0, F, 4'h7, 64'h55, 64'hA);
        tick();
        check("stall1_icode", E_icode, 4'h6);
        tick();
        check("stall2_icode", E_icode, 4'h6);
        check("stall2_dstE", E_dstE, 4'h3);
        D_stall = 0;
        tick();
        check("stall3_icode", E_icode, 4'h6);
        set_f(3'b001, 4'h1, 4'h0, F, F, 0, 0);
        tick();
        check("after_stall", E_icode, 4'h3);

        // E bubble with D stall: E becomes nop, D retains its instruction.
        set_f(3'b001, 4'h6, 4'h0, 4'h2, 4'h3, 0, 2);
        tick();
        D_stall = 1; E_bubble = 1;
        set_f(3'b001, 4'h5, 4'h0, 4'h0, 4'h6, 8, 10);
        tick();
        check("ebub_icode", E_icode, 4'h1);
        check("ebub_dstE", E_dstE, F);
        D_stall = 0; E_bubble = 0;
        set_f(3'b001, 4'h1, 4'h0, F, F, 0, 0);
        tick();
        check("ebub_dkept", E_icode, 4'h6);

        // Stall beats bubble on D; bubble alone inserts a nop.
        set_f(3'b001, 4'h6, 4'h0, 4'h2, 4'h3, 0, 2);
        tick();
        D_stall = 1; D_bubble = 1;
        set_f(3'b001, 4'h5, 4'h0, 4'h0, 4'h6, 8, 10);
        tick();
        D_stall = 0; D_bubble = 1;
        tick();
        check("stall_wins", E_icode, 4'h6);
        D_bubble = 0;
        tick();
        check("dbub_nop", E_icode, 4'h1);

        // Dual write to one register: M port wins; F destination does not write.
        W_dstE = 4'h6; W_valE = 64'd1; W_dstM = 4'h6; W_valM = 64'd2;
        dbg_sel = 4'h6;
        tick();
        check("dual_wr", dbg_val, 64'd2);
        W_dstE = F; W_valE = 64'd99; W_dstM = F; W_valM = 64'd77;
        tick();
        check("no_wr", dbg_val, 64'd2);
        dbg_sel = F;
        #1;
        check("dbg_F", dbg_val, 64'h0);
        set_idle();

        // Mid-run reset with live E contents and non-zero rf[3].
        set_f(3'b001, 4'h6, 4'h0, 4'h2, 4'h3, 0, 2);
        tick();
        tick();
        #2;
        do_reset();

        for (int n = 0; n < 600; n++) begin
            logic [2:0] st;
            st = 3'b001 << $urandom_range(0, 2);
            set_f(st, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, {$urandom, $urandom});
            e_dstE = 4'($urandom_range(0, 15)); e_valE = {$urandom, $urandom};
            M_dstE = 4'($urandom_range(0, 15)); M_valE = {$urandom, $urandom};
            M_dstM = 4'($urandom_range(0, 15)); m_valM = {$urandom, $urandom};
            W_dstE = 4'($urandom_range(0, 15)); W_valE = {$urandom, $urandom};
            W_dstM = 4'($urandom_range(0, 15)); W_valM = {$urandom, $urandom};
            D_stall = ($urandom_range(0, 7) == 0);
            D_bubble = ($urandom_range(0, 7) == 0);
            E_bubble = ($urandom_range(0, 9) == 0);
            dbg_sel = 4'($urandom_range(0, 15));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
